task_8_packet_framer: RTL and testbench
=======================================

// Module: task_8_packet_framer
// PURPOSE
//  Stage downstream of the FIFO-draining input stage. Captures the byte burst that stage emits (data + enable strobe) into
//  a local buffer, then replays it as an AXI-Stream packet. The packet ends with an 8-bit checksum byte carrying tlast.
//  Reports busy/overflow status so the system controller can pace the input stage.
// PARAMETERS
//  DEPTH    64  max payload bytes per packet (power of 2, >=2)
//  AW       $clog2(DEPTH)  buffer address width (derived, not overridden)
// PORTS
//  i_clk       in   1    single clock, all logic rising-edge
//  i_rst_n     in   1    asynchronous, active-low reset
//  i_data      in   8    payload byte from input stage
//  i_enb       in   1    i_data valid this cycle (one byte per high cycle)
//  o_tdata     out  8    AXI-S data
//  o_tvalid    out  1    AXI-S valid
//  o_tlast     out  1    high with checksum byte only
//  i_tready    in   1    AXI-S ready from consumer
//  o_busy      out  1    high in s_SEND/s_CSUM; input not accepted
//  o_overflow  out  1    sticky: byte dropped (buffer full or arrived while busy)
//  o_pkt_len   out  AW+1 payload length of packet being sent (valid while o_busy)
// BEHAVIOUR
//  Reset (async assert, sync release): state=s_IDLE, all outputs 0, wr/rd pointers 0, checksum accumulator 0.
//  States: s_IDLE, s_COLLECT, s_SEND, s_CSUM.
//  s_IDLE: i_enb=1 -> write byte at addr 0, len=1, sum=i_data, go s_COLLECT.
//  s_COLLECT: i_enb=1 -> write byte if len<DEPTH, len++, sum+=i_data (mod 256); len==DEPTH -> drop, set o_overflow.
//   i_enb=0 -> packet closed; latch o_pkt_len=len; go s_SEND. (First low cycle after >=1 byte ends the packet.)
//  s_SEND: o_tvalid=1 registered; o_tvalid rises the cycle after entering s_SEND (2 cycles after last i_enb).
//   o_tdata=buf[rd]; on tvalid&&tready rd++; after byte len-1 accepted -> s_CSUM.
//   o_tdata/o_tvalid hold stable while tready=0 (AXI rule); no bubble between accepted bytes.
//  s_CSUM: o_tdata=~sum, o_tvalid=1, o_tlast=1; on tready -> s_IDLE, pointers/len/sum cleared.
//  Checksum: ~(sum of payload mod 256); sum of all bytes incl. checksum == 8'hFF.
//  i_enb during s_SEND/s_CSUM: byte dropped, o_overflow set; never corrupts packet in flight.
//  o_overflow clears only on reset.
//  Async reset mid-packet: output abandoned, o_tvalid drops immediately; no partial tlast emitted.
//  Buffer: simple dual-port, registered read; read address pre-fetched so o_tdata valid with o_tvalid.
// STRUCTURE
//  task_8_pkg: typedef enum framer_state_t {s_IDLE,s_COLLECT,s_SEND,s_CSUM}; localparam CSUM_INIT=8'h00.
//  Sub-module task_8_framer_ram: DEPTHx8 simple dual-port RAM, 1-cycle read latency, no reset on array.
//  Top holds FSM, pointers, length counter, checksum accumulator, AXI output registers.
// TESTING
//  Bytes 01,02,03 on consecutive i_enb, tready=1 -> out 01,02,03,F9(tlast); tvalid 2 cycles after last enb.
//  Single byte FF -> out FF,00(tlast); o_pkt_len=1.
//  DEPTH+2 bytes -> first DEPTH bytes + checksum out, o_overflow=1 sticky.
//  3-byte packet, tready toggling 1,0,0,1... -> each byte held stable while tready=0; order and checksum intact.
//  i_enb pulse during s_SEND -> in-flight packet unchanged, o_overflow=1, next packet after IDLE correct.
//  i_rst_n low mid-s_SEND -> tvalid/busy 0 asynchronously; next packet 0A,0B -> out 0A,0B,EA(tlast).

Source files
------------

// File: rtl/task_8_pkg.sv
//------------------------------------------------------------------------------
// task_8_pkg : shared state encoding and checksum helpers for the packet framer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package task_8_pkg;

  typedef enum logic [1:0] {
    s_IDLE    = 2'd0,
    s_COLLECT = 2'd1,
    s_SEND    = 2'd2,
    s_CSUM    = 2'd3
  } framer_state_t;

  localparam logic [7:0] CSUM_INIT = 8'h00;

  // Transmitted checksum byte makes the sum of the whole packet 8'hFF.
  function automatic logic [7:0] csum_final(input logic [7:0] sum);
    return ~sum;
  endfunction

endpackage

`default_nettype wire

// File: rtl/task_8_framer_ram.sv
//------------------------------------------------------------------------------
// task_8_framer_ram : DEPTH x 8 simple dual-port RAM, one-cycle registered read
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module task_8_framer_ram
  import task_8_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  // Only the read register is reset so the framer's data output is 0 out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdata_q <= '0;
    end else if (i_re) begin
      rdata_q <= mem_q[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/task_8_packet_framer.sv
//------------------------------------------------------------------------------
// task_8_packet_framer : buffers an input byte burst, replays it on AXI-Stream
//                        followed by a tlast checksum byte.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module task_8_packet_framer
  import task_8_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_enb,
  output logic [7:0]  o_tdata,
  output logic        o_tvalid,
  output logic        o_tlast,
  input  logic        i_tready,
  output logic        o_busy,
  output logic        o_overflow,
  output logic [AW:0] o_pkt_len
);

  localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  framer_state_t state_q;
  logic [AW:0]   len_q;
  logic [AW:0]   rd_q;
  logic [AW:0]   pkt_len_q;
  logic [7:0]    sum_q;
  logic          tvalid_q;
  logic          tlast_q;
  logic          overflow_q;

  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [7:0]    ram_rdata;
  logic          accept;
  logic          last_payload;

  // rd_q is the next address to fetch, so it equals pkt_len once the final
  // payload byte sits in the RAM read register.
  assign accept       = tvalid_q & i_tready;
  assign last_payload = (rd_q == pkt_len_q);

  assign ram_we    = i_enb & ((state_q == s_IDLE) |
                              ((state_q == s_COLLECT) & (len_q != FULL_LEN)));
  assign ram_waddr = len_q[AW-1:0];
  assign ram_re    = (state_q == s_SEND) & (~tvalid_q | (accept & ~last_payload));
  assign ram_raddr = rd_q[AW-1:0];

  task_8_framer_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (ram_we),
    .i_waddr (ram_waddr),
    .i_wdata (i_data),
    .i_re    (ram_re),
    .i_raddr (ram_raddr),
    .o_rdata (ram_rdata)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= s_IDLE;
      len_q      <= '0;
      rd_q       <= '0;
      pkt_len_q  <= '0;
      sum_q      <= CSUM_INIT;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        s_IDLE: begin
          if (i_enb) begin
            len_q   <= ONE;
            sum_q   <= i_data;
            state_q <= s_COLLECT;
          end
        end

        s_COLLECT: begin
          if (i_enb) begin
            if (len_q != FULL_LEN) begin
              len_q <= len_q + ONE;
              sum_q <= sum_q + i_data;
            end else begin
              overflow_q <= 1'b1;
            end
          end else begin
            pkt_len_q <= len_q;
            rd_q      <= '0;
            state_q   <= s_SEND;
          end
        end

        s_SEND: begin
          if (i_enb) begin
            overflow_q <= 1'b1;
          end
          if (!tvalid_q) begin
            tvalid_q <= 1'b1;
            rd_q     <= rd_q + ONE;
          end else if (i_tready) begin
            if (last_payload) begin
              tlast_q <= 1'b1;
              state_q <= s_CSUM;
            end else begin
              rd_q <= rd_q + ONE;
            end
          end
        end

        s_CSUM: begin
          if (i_enb) begin
            overflow_q <= 1'b1;
          end
          if (i_tready) begin
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            len_q     <= '0;
            rd_q      <= '0;
            pkt_len_q <= '0;
            sum_q     <= CSUM_INIT;
            state_q   <= s_IDLE;
          end
        end

        default: begin
          state_q <= s_IDLE;
        end
      endcase
    end
  end

  assign o_tdata    = tlast_q ? csum_final(sum_q) : ram_rdata;
  assign o_tvalid   = tvalid_q;
  assign o_tlast    = tlast_q;
  assign o_busy     = (state_q == s_SEND) | (state_q == s_CSUM);
  assign o_overflow = overflow_q;
  assign o_pkt_len  = pkt_len_q;

endmodule

`default_nettype wire

// File: tb/tb_task_8_packet_framer.sv
//------------------------------------------------------------------------------
// tb_task_8_packet_framer : directed vectors and corner sequences for the framer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_task_8_packet_framer;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic        clk;
  logic        rst_n;
  logic [7:0]  i_data;
  logic        i_enb;
  logic [7:0]  o_tdata;
  logic        o_tvalid;
  logic        o_tlast;
  logic        i_tready;
  logic        o_busy;
  logic        o_overflow;
  logic [AW:0] o_pkt_len;

  task_8_packet_framer #(.DEPTH(DEPTH)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_data     (i_data),
    .i_enb      (i_enb),
    .o_tdata    (o_tdata),
    .o_tvalid   (o_tvalid),
    .o_tlast    (o_tlast),
    .i_tready   (i_tready),
    .o_busy     (o_busy),
    .o_overflow (o_overflow),
    .o_pkt_len  (o_pkt_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [3:0][7:0]  pay;
    logic [7:0]       csum;
    logic [3:0]       mask;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] in_buf  [128];
  logic [7:0] exp_buf [128];
  int         exp_len;
  int         tests;
  int         failed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Feed n bytes from in_buf, then verify tvalid timing and the latched length.
  task automatic send(input int n, input int exp_pkt_len);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_enb  = 1'b1;
      i_data = in_buf[i];
    end
    @(negedge clk);
    i_enb  = 1'b0;
    i_data = 8'h00;
    check("tvalid low 1 cycle after enb", 32'(o_tvalid), 32'd0);
    @(negedge clk);
    check("tvalid low entering send", 32'(o_tvalid), 32'd0);
    check("busy in send", 32'(o_busy), 32'd1);
    check("pkt_len", 32'(o_pkt_len), 32'(exp_pkt_len));
    @(negedge clk);
    check("tvalid 2 cycles after enb", 32'(o_tvalid), 32'd1);
  endtask

  // Drain the stream with a repeating 4-cycle tready mask and compare against exp_buf.
  task automatic recv(input string name, input logic [3:0] mask);
    int         k = 0;
    int         cyc = 0;
    bit         done = 0;
    bit         prev_stall = 0;
    logic [7:0] pd = 8'h00;
    logic       pl = 1'b0;
    logic [7:0] s = 8'h00;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      if (prev_stall) begin
        check({name, " hold"}, {23'd0, o_tvalid, o_tlast, o_tdata}, {23'd0, 1'b1, pl, pd});
      end
      i_tready = mask[cyc % 4];
      if (o_tvalid && i_tready) begin
        if (k < exp_len) begin
          check({name, " data"}, 32'(o_tdata), 32'(exp_buf[k]));
          check({name, " tlast"}, 32'(o_tlast), 32'(k == exp_len - 1));
        end else begin
          check({name, " extra byte"}, 32'(k), 32'(exp_len - 1));
        end
        s = s + o_tdata;
        k++;
        if (o_tlast) done = 1;
      end
      prev_stall = o_tvalid && !i_tready;
      pd = o_tdata;
      pl = o_tlast;
      cyc++;
    end
    if (!done) begin
      check({name, " timeout"}, 32'd0, 32'd1);
    end
    check({name, " byte count"}, 32'(k), 32'(exp_len));
    check({name, " sum FF"}, 32'(s), 32'hFF);
    @(negedge clk);
    i_tready = 1'b0;
    check({name, " idle tvalid"}, 32'(o_tvalid), 32'd0);
    check({name, " idle busy"}, 32'(o_busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests    = 0;
    failed   = 0;
    rst_n    = 1'b0;
    i_data   = 8'h00;
    i_enb    = 1'b0;
    i_tready = 1'b0;

    vecs[0] = '{n: 3, pay: {8'h00, 8'h03, 8'h02, 8'h01}, csum: 8'hF9, mask: 4'b1111};
    vecs[1] = '{n: 1, pay: {8'h00, 8'h00, 8'h00, 8'hFF}, csum: 8'h00, mask: 4'b1111};
    vecs[2] = '{n: 3, pay: {8'h00, 8'h30, 8'h20, 8'h10}, csum: 8'h9F, mask: 4'b1001};
    vecs[3] = '{n: 4, pay: {8'h01, 8'h7F, 8'h80, 8'h80}, csum: 8'h7F, mask: 4'b0101};
    vecs[4] = '{n: 2, pay: {8'h00, 8'h00, 8'h0B, 8'h0A}, csum: 8'hEA, mask: 4'b0110};

    repeat (2) @(negedge clk);
    check("reset tvalid", 32'(o_tvalid), 32'd0);
    check("reset tlast", 32'(o_tlast), 32'd0);
    check("reset tdata", 32'(o_tdata), 32'd0);
    check("reset busy", 32'(o_busy), 32'd0);
    check("reset overflow", 32'(o_overflow), 32'd0);
    check("reset pkt_len", 32'(o_pkt_len), 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      for (int j = 0; j < vecs[v].n; j++) begin
        in_buf[j]  = vecs[v].pay[j];
        exp_buf[j] = vecs[v].pay[j];
      end
      exp_buf[vecs[v].n] = vecs[v].csum;
      exp_len = vecs[v].n + 1;
      send(vecs[v].n, vecs[v].n);
      recv($sformatf("vec%0d", v), vecs[v].mask);
      check($sformatf("vec%0d overflow", v), 32'(o_overflow), 32'd0);
    end

    // Async reset while a packet is mid-transmission.
    in_buf[0] = 8'h11; in_buf[1] = 8'h22; in_buf[2] = 8'h33;
    send(3, 3);
    @(negedge clk);
    i_tready = 1'b1;
    @(negedge clk);
    i_tready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async rst tvalid", 32'(o_tvalid), 32'd0);
    check("async rst busy", 32'(o_busy), 32'd0);
    check("async rst tlast", 32'(o_tlast), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_buf[0] = 8'h0A; in_buf[1] = 8'h0B;
    exp_buf[0] = 8'h0A; exp_buf[1] = 8'h0B; exp_buf[2] = 8'hEA;
    exp_len = 3;
    send(2, 2);
    recv("post reset", 4'b1111);

    // Stray enable while the packet is being sent.
    in_buf[0] = 8'h05; in_buf[1] = 8'h06; in_buf[2] = 8'h07;
    exp_buf[0] = 8'h05; exp_buf[1] = 8'h06; exp_buf[2] = 8'h07; exp_buf[3] = 8'hED;
    exp_len = 4;
    send(3, 3);
    @(negedge clk);
    i_enb  = 1'b1;
    i_data = 8'hAA;
    @(negedge clk);
    i_enb  = 1'b0;
    i_data = 8'h00;
    check("enb in send overflow", 32'(o_overflow), 32'd1);
    check("enb in send pkt_len", 32'(o_pkt_len), 32'd3);
    recv("enb in send", 4'b1111);
    in_buf[0] = 8'h01; in_buf[1] = 8'h02; in_buf[2] = 8'h03;
    exp_buf[0] = 8'h01; exp_buf[1] = 8'h02; exp_buf[2] = 8'h03; exp_buf[3] = 8'hF9;
    exp_len = 4;
    send(3, 3);
    recv("after stray enb", 4'b1111);
    check("overflow sticky", 32'(o_overflow), 32'd1);

    // DEPTH+2 bytes: the last two are dropped.
    do_reset();
    check("overflow cleared by reset", 32'(o_overflow), 32'd0);
    for (int i = 0; i < DEPTH + 2; i++) in_buf[i] = 8'(i + 1);
    for (int i = 0; i < DEPTH; i++) exp_buf[i] = 8'(i + 1);
    exp_buf[DEPTH] = 8'hDF;
    exp_len = DEPTH + 1;
    send(DEPTH + 2, DEPTH);
    check("full overflow", 32'(o_overflow), 32'd1);
    recv("full", 4'b1111);
    check("full overflow sticky", 32'(o_overflow), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
